sequence_word_encoder: RTL



---
 rtl/sequence_word_encoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sequence_word_encoder.sv
// Assembles controller field writes into a shadow entry, commits it to a one-deep pending slot, and emits the packed word on each step.
// A committed entry appears at the first step edge after its commit; wr_ready is low while an entry is pending.
module sequence_word_encoder #(
    parameter int STEP_W = 32
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [STEP_W-1:0] samples_per_step,
    input  logic              run,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [3:0]        wr_field,
    input  logic [15:0]       wr_data,
    input  logic              wr_last,
    output logic [127:0]      seq_data,
    output logic              step_tick,
    output logic [STEP_W-1:0] step_count,
    output logic              underrun
);

    typedef struct packed {
        logic [1:0]       resync;
        logic [1:0]       ramp_down;
        logic [3:0]       enable_pdm;
        logic [1:0]       enable_dac;
        logic [3:0][10:0] pdm;
        logic [13:0]      dac1;
        logic [13:0]      dac0;
    } shadow_t;

    function automatic logic [127:0] pack_word(input shadow_t s);
        logic [127:0] w;
        w            = '0;
        w[13:0]      = s.dac0;
        w[14]        = s.resync[0];
        w[29:16]     = s.dac1;
        w[30]        = s.resync[1];
        for (int k = 0; k < 4; k++) begin
            w[32 + 16*k +: 11] = s.pdm[k];
        end
        w[97:96]     = s.enable_dac;
        w[101:98]    = s.enable_pdm;
        w[113:112]   = s.ramp_down;
        return w;
    endfunction

    shadow_t           shadow_q, shadow_d;
    logic [127:0]      pend_q, pend_d;
    logic              pend_v_q, pend_v_d;
    logic [127:0]      seq_q, seq_d;
    logic              tick_q;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              underrun_q, underrun_d;
    logic              run_q;

    logic              wr_acc;
    logic              start;
    logic              period_done;
    logic              step;
    logic [STEP_W-1:0] period_m1;

    assign wr_acc      = wr_valid & ~pend_v_q;
    assign period_m1   = (samples_per_step == '0) ? '0 : samples_per_step - STEP_W'(1);
    // >= rather than == so a shortened period forces a step at once
    assign period_done = (cnt_q >= period_m1);
    assign start       = run & ~run_q;
    assign step        = run & (~run_q | period_done);

    always_comb begin
        shadow_d = shadow_q;
        if (wr_acc) begin
            case (wr_field)
                4'd0: shadow_d.dac0   = wr_data[15:2];
                4'd1: shadow_d.dac1   = wr_data[15:2];
                4'd2: shadow_d.pdm[0] = wr_data[10:0];
                4'd3: shadow_d.pdm[1] = wr_data[10:0];
                4'd4: shadow_d.pdm[2] = wr_data[10:0];
                4'd5: shadow_d.pdm[3] = wr_data[10:0];
                4'd6: begin
                    shadow_d.enable_dac = wr_data[1:0];
                    shadow_d.enable_pdm = wr_data[5:2];
                    shadow_d.ramp_down  = wr_data[7:6];
                    shadow_d.resync     = wr_data[9:8];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        seq_d      = seq_q;
        underrun_d = underrun_q;
        step_cnt_d = step_cnt_q;
        cnt_d      = cnt_q;

        if (!run || step) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + STEP_W'(1);
        end

        if (start) begin
            step_cnt_d = '0;
            underrun_d = 1'b0;
        end else if (step) begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
        end

        // A step with nothing pending still counts as a step and flags underrun
        if (step) begin
            if (pend_v_q) begin
                seq_d    = pend_q;
                pend_v_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        // Only possible with pend_v_q low, so never collides with a consume
        if (wr_acc && wr_last) begin
            pend_d   = pack_word(shadow_d);
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            shadow_q   <= '0;
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            seq_q      <= '0;
            tick_q     <= 1'b0;
            cnt_q      <= '0;
            step_cnt_q <= '0;
            underrun_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            seq_q      <= seq_d;
            tick_q     <= step;
            cnt_q      <= cnt_d;
            step_cnt_q <= step_cnt_d;
            underrun_q <= underrun_d;
            run_q      <= run;
        end
    end

    assign wr_ready   = ~pend_v_q;
    assign seq_data   = seq_q;
    assign step_tick  = tick_q;
    assign step_count = step_cnt_q;
    assign underrun   = underrun_q;

endmodule
